// File: rtl/simpson_param_ctrl.sv
// ============================================================================
// Module   : simpson_param_ctrl
// Purpose  : Front-panel button debounce and parameter entry / run control
//            for the Simpson's-rule integration engine.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module simpson_param_ctrl #(
    parameter int WIDTH     = 8,
    parameter int N_MAX     = 64,
    parameter int DB_CYCLES = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       btn_inc,
    input  logic                       btn_dec,
    input  logic                       btn_next,
    input  logic                       btn_start,
    input  logic                       done,
    output logic [WIDTH-1:0]           a_val,
    output logic [WIDTH-1:0]           b_val,
    output logic [$clog2(N_MAX+1)-1:0] n_val,
    output logic [1:0]                 field_sel,
    output logic                       start,
    output logic                       busy,
    output logic [1:0]                 err
);

    localparam int NW  = $clog2(N_MAX + 1);
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [WIDTH-1:0] A_MAX = '1;
    localparam logic [NW-1:0]    N_HI  = NW'(N_MAX);
    localparam logic [NW-1:0]    N_LO  = NW'(2);

    localparam logic [2:0] S_EDIT_A = 3'd0;
    localparam logic [2:0] S_EDIT_B = 3'd1;
    localparam logic [2:0] S_EDIT_N = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;

    // Bit order: 0 inc, 1 dec, 2 next, 3 start
    logic [3:0] raw;
    logic [3:0] press;

    assign raw = {btn_start, btn_next, btn_dec, btn_inc};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic           sync1;
        logic           sync2;
        logic           stable;
        logic           stable_d;
        logic           pulse;
        logic [DBW-1:0] db_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1    <= 1'b0;
                sync2    <= 1'b0;
                stable   <= 1'b0;
                stable_d <= 1'b0;
                pulse    <= 1'b0;
                db_cnt   <= '0;
            end else begin
                sync1    <= raw[i];
                sync2    <= sync1;
                stable_d <= stable;
                pulse    <= stable & ~stable_d;
                if (sync2 == stable) begin
                    db_cnt <= '0;
                end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
                    stable <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DBW'(1);
                end
            end
        end

        assign press[i] = pulse;
    end

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [TW-1:0] to_cnt;
    logic          editing;
    logic          params_ok;
    logic          timed_out;
    logic          act_start;
    logic          act_next;
    logic          act_inc;
    logic          act_dec;

    // One action per cycle; lower-priority pulses are simply dropped.
    assign act_start = press[3];
    assign act_next  = press[2] & ~press[3];
    assign act_inc   = press[0] & ~press[2] & ~press[3];
    assign act_dec   = press[1] & ~press[0] & ~press[2] & ~press[3];

    assign editing   = (state == S_EDIT_A) || (state == S_EDIT_B) || (state == S_EDIT_N);
    assign params_ok = (a_val < b_val);
    assign timed_out = (to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_EDIT_A;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_EDIT_A, S_EDIT_B, S_EDIT_N: begin
                if (act_start) begin
                    if (params_ok) state_next = S_RUN;
                end else if (act_next) begin
                    case (state)
                        S_EDIT_A: state_next = S_EDIT_B;
                        S_EDIT_B: state_next = S_EDIT_N;
                        default:  state_next = S_EDIT_A;
                    endcase
                end
            end
            S_RUN:   state_next = S_WAIT;
            S_WAIT:  if (done || timed_out) state_next = S_EDIT_A;
            default: state_next = S_EDIT_A;
        endcase
    end

    always_comb begin
        start     = (state == S_RUN);
        busy      = (state == S_RUN) || (state == S_WAIT);
        field_sel = 2'd3;
        case (state)
            S_EDIT_A: field_sel = 2'd0;
            S_EDIT_B: field_sel = 2'd1;
            S_EDIT_N: field_sel = 2'd2;
            default:  field_sel = 2'd3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_val  <= '0;
            b_val  <= WIDTH'(1);
            n_val  <= N_LO;
            err    <= 2'd0;
            to_cnt <= '0;
        end else if (editing) begin
            if (act_start) begin
                if (!params_ok) err <= 2'd1;
            end else if (act_next) begin
                err <= 2'd0;
            end else if (act_inc || act_dec) begin
                err <= 2'd0;
                case (state)
                    S_EDIT_A: begin
                        if (act_inc && a_val != A_MAX) a_val <= a_val + WIDTH'(1);
                        if (act_dec && a_val != '0)    a_val <= a_val - WIDTH'(1);
                    end
                    S_EDIT_B: begin
                        if (act_inc && b_val != A_MAX) b_val <= b_val + WIDTH'(1);
                        if (act_dec && b_val != '0)    b_val <= b_val - WIDTH'(1);
                    end
                    default: begin
                        if (act_inc && n_val < N_HI) n_val <= n_val + NW'(2);
                        if (act_dec && n_val > N_LO) n_val <= n_val - NW'(2);
                    end
                endcase
            end
        end else if (state == S_RUN) begin
            to_cnt <= '0;
        end else if (state == S_WAIT) begin
            to_cnt <= to_cnt + TW'(1);
            // done outranks a coincident timeout
            if (done)           err <= 2'd0;
            else if (timed_out) err <= 2'd2;
        end
    end

endmodule

`default_nettype wire
